// File: rtl/bcd_display_mux.sv
// Two-digit common-anode 7-segment display multiplexer with per-frame digit snapshot,
// dead-time blanking and sticky overflow on the tens DP. Optional: LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
    parameter int REFRESH_DIV  = 1200,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_10,
    input  logic       carry,
    input  logic       ovf_clr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_sel,
    output logic       frame_tick
);
    localparam int TW = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - BLANK_CYCLES - 1);

    typedef enum logic [1:0] {BLANK_0, SHOW_0, BLANK_1, SHOW_1} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    shadow_1_q, shadow_1_d, shadow_10_q, shadow_10_d;
    logic          ovf_q, ovf_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [1:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          slot_end;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        shadow_1_d  = shadow_1_q;
        shadow_10_d = shadow_10_q;
        slot_end    = (state_q == BLANK_0 || state_q == BLANK_1) ? (timer_q == BLANK_LAST)
                                                                 : (timer_q == SHOW_LAST);
        if (slot_end) begin
            timer_d = '0;
            case (state_q)
                BLANK_0: state_d = SHOW_0;
                SHOW_0:  state_d = BLANK_1;
                BLANK_1: state_d = SHOW_1;
                default: state_d = BLANK_0;
            endcase
            // Snapshot only at frame boundary so a frame never mixes old and new digits
            if (state_q == SHOW_1) begin
                shadow_1_d  = digit_1;
                shadow_10_d = digit_10;
            end
        end
        tick_d = (state_d == SHOW_1) && (timer_d == SHOW_LAST);

        if (carry)        ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;

        seg_d = 7'h7F;
        dp_d  = 1'b1;
        sel_d = 2'b11;
        case (state_q)
            SHOW_0: begin
                sel_d = 2'b10;
                seg_d = decode(shadow_1_q);
            end
            SHOW_1: begin
                sel_d = 2'b01;
                dp_d  = ~ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
                seg_d = (shadow_10_q == 4'd0) ? 7'h7F : decode(shadow_10_q);
`else
                seg_d = decode(shadow_10_q);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BLANK_0;
            timer_q     <= '0;
            shadow_1_q  <= '0;
            shadow_10_q <= '0;
            ovf_q       <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            sel_q       <= 2'b11;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            shadow_1_q  <= shadow_1_d;
            shadow_10_q <= shadow_10_d;
            ovf_q       <= ovf_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_tick = tick_q;
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
Downstream consumer of the two-digit BCD counter pair (units, tens, carry). Drives a common-anode, time-multiplexed two-digit 7-segment display with dead-time blanking between digit slots. Latches a snapshot of both digits once per frame so the display never tears. Turns the counter's carry output into a sticky overflow indicator shown on the tens decimal point.

Parameters:
REFRESH_DIV, 1200, clocks per digit slot (blank + show); must be > BLANK_CYCLES
BLANK_CYCLES, 16, clocks per slot with all digits off (anti-ghosting); must be >= 1

Ports:
clk  in  1  system clock, all flops rising-edge
reset  in  1  asynchronous, active-low reset
digit_1  in  4  units BCD digit from counter
digit_10  in  4  tens BCD digit from counter
carry  in  1  counter overflow, level-sampled each clk
ovf_clr  in  1  synchronous clear of the sticky overflow flag
seg  out  7  segments, bit0=a … bit6=g, active-low
dp  out  1  decimal point, active-low
digit_sel  out  2  digit enables, bit0=units, bit1=tens, active-low
frame_tick  out  1  one-clock pulse at each frame start

Behaviour:
- Reset (reset=0, async): state=BLANK_0, timer=0, shadow_1=shadow_10=0, ovf=0; seg=7'h7F, dp=1, digit_sel=2'b11, frame_tick=0.
- FSM cycles BLANK_0 -> SHOW_0 -> BLANK_1 -> SHOW_1 -> BLANK_0.
  - Each BLANK state lasts BLANK_CYCLES clocks.
  - Each SHOW state lasts REFRESH_DIV-BLANK_CYCLES clocks.
  - Frame = 2*REFRESH_DIV clocks.
- timer counts 0 up to (state length - 1), then resets to 0 when the state advances. Width = clog2(REFRESH_DIV).
- Snapshot: on the SHOW_1 -> BLANK_0 transition edge, shadow_1<=digit_1 and shadow_10<=digit_10. frame_tick is high for exactly that one clock.
  - Inputs are ignored at all other times.
  - First frame after reset shows shadow values 0/0.
- Outputs are registered: they reflect the FSM state one clock after that state is entered.
  - BLANK_x: digit_sel=2'b11, seg=7'h7F, dp=1.
  - SHOW_0: digit_sel=2'b10, seg=decode(shadow_1), dp=1.
  - SHOW_1: digit_sel=2'b01, seg=decode(shadow_10), dp=~ovf.
- Decode, active-low, gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - Invalid 10–15 = 3F (minus sign, g only).
- Overflow flag:
  - carry=1 sampled -> ovf<=1.
  - ovf_clr=1 -> ovf<=0.
  - Both high in the same cycle -> set wins (ovf=1).
  - ovf updates continuously, not per-frame.
- Reset asserted mid-frame: immediate return to reset values. After release, the first rising edge starts BLANK_0 with timer=0.
- Never more than one digit enable active. Any change of digit_sel passes through 2'b11 for at least BLANK_CYCLES clocks.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: in SHOW_1, if shadow_10==0, seg=7'h7F. digit_sel and dp behave as normal, so an overflow dp is still visible.
- Undefined: tens digit 0 displays 7'h40.
- Units digit is never blanked in either build.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset low, then release -> all outputs at reset values. frame_tick first pulses at clock 15 after release (end of first SHOW_1). Period 16 thereafter.
2. digit_10=4, digit_1=7 held -> second frame shows SHOW_0 seg=78 with digit_sel=10, and SHOW_1 seg=19 with digit_sel=01. Each slot has 6 active clocks and 2 blank clocks.
3. Change digit_1 from 2 to 9 mid-SHOW_0 -> seg stays 24 until the next frame_tick, then shows 10.
4. digit_1=4'hC -> seg=3F in the units slot.
5. carry pulse for 1 clk -> dp=0 during every SHOW_1 until ovf_clr. carry and ovf_clr asserted together -> ovf stays 1.
6. digit_10=0, units 5 -> SHOW_1 seg=40 without the macro, 7F with LEADING_ZERO_BLANK_EN. Reset pulled low mid-SHOW_1 -> digit_sel=11 within the same cycle (async).
